// File: rtl/segway_pkg.sv
// Shared Segway definitions: A2D scheduler state encoding, default ADC channel map
// and the SPI command-word builder used by the A2D scheduler.
package segway_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER1,
    GAP,
    XFER2
  } a2d_state_t;

  localparam logic [2:0] A2D_CH_LFT   = 3'd0;
  localparam logic [2:0] A2D_CH_RGHT  = 3'd4;
  localparam logic [2:0] A2D_CH_STEER = 3'd5;
  localparam logic [2:0] A2D_CH_BATT  = 3'd6;
  localparam int         A2D_TMO_CYC  = 2048;

  // ADC128S control word: the channel address sits in bits [13:11], everything else zero.
  function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_scheduler.sv
// Round-robin A2D scheduler: each nxt runs an address frame and a data frame on the
// shared SPI monarch and stores the 12-bit result of the addressed channel.
module a2d_scheduler
  import segway_pkg::*;
#(
  parameter logic [2:0] CH_LFT   = A2D_CH_LFT,
  parameter logic [2:0] CH_RGHT  = A2D_CH_RGHT,
  parameter logic [2:0] CH_STEER = A2D_CH_STEER,
  parameter logic [2:0] CH_BATT  = A2D_CH_BATT,
  parameter int         TMO_CYC  = A2D_TMO_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output logic        busy,
  output logic        err
);

  localparam int            TW       = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  a2d_state_t    state_q;
  logic [1:0]    rr_q, rr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          wrt_q, vld_q, busy_q, err_q;
  logic [11:0]   lft_q, rght_q, steer_q, batt_q;
  logic          tmo_hit;
  logic          unused_rd;

  always_comb begin
    cmd_d = a2d_cmd(CH_LFT);
    case (rr_q)
      2'd0: cmd_d = a2d_cmd(CH_LFT);
      2'd1: cmd_d = a2d_cmd(CH_RGHT);
      2'd2: cmd_d = a2d_cmd(CH_STEER);
      2'd3: cmd_d = a2d_cmd(CH_BATT);
    endcase
  end

  assign rr_d      = rr_q + 2'd1;
  assign tmo_d     = tmo_q + TW'(1);
  assign tmo_hit   = (tmo_q == TMO_LAST);
  // The ADC only drives a 12-bit result; the top nibble of the frame carries no data.
  assign unused_rd = ^rd_data[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      tmo_q   <= '0;
      cmd_q   <= 16'h0000;
      wrt_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
      batt_q  <= 12'h000;
    end else begin
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (nxt) begin
            cmd_q   <= cmd_d;
            wrt_q   <= 1'b1;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
            state_q <= XFER1;
          end
        end
        XFER1: begin
          if (done) begin
            state_q <= GAP;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        // One dead cycle lets SS_n rise between frames; cmd_q is reused unchanged.
        GAP: begin
          wrt_q   <= 1'b1;
          tmo_q   <= '0;
          state_q <= XFER2;
        end
        XFER2: begin
          if (done) begin
            case (rr_q)
              2'd0: lft_q   <= rd_data[11:0];
              2'd1: rght_q  <= rd_data[11:0];
              2'd2: steer_q <= rd_data[11:0];
              2'd3: batt_q  <= rd_data[11:0];
            endcase
            vld_q   <= 1'b1;
            rr_q    <= rr_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign vld       = vld_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;

endmodule

// File: doc/a2d_scheduler.md
Name: a2d_scheduler

Overview:
- Sequences the shared SPI link to the ADC128S 8-channel A2D.
- Each `nxt` request performs one round-robin conversion over four channels: left load cell, right load cell, steering pot and battery.
- Each conversion is two back-to-back 16-bit SPI transactions. The first sends the channel address; the second returns that channel's 12-bit result.
- Sits between the balance/steer/battery logic (consumers) and an external SPI monarch (the bit-level shifter).

Parameters:
- CH_LFT, 3'd0, ADC channel for the left load cell
- CH_RGHT, 3'd4, ADC channel for the right load cell
- CH_STEER, 3'd5, ADC channel for the steering pot
- CH_BATT, 3'd6, ADC channel for the battery
- TMO_CYC, 2048, max clocks to wait for `done` before aborting

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- nxt  in  1  pulse: start the next round-robin conversion
- wrt  out  1  one-cycle pulse to the SPI monarch: start a transaction
- cmd  out  16  SPI transmit word
- done  in  1  one-cycle pulse from the SPI monarch: transaction complete
- rd_data  in  16  SPI receive word, valid while `done`=1
- lft_ld  out  12  last left load-cell result
- rght_ld  out  12  last right load-cell result
- steer_pot  out  12  last steering pot result
- batt  out  12  last battery result
- vld  out  1  one-cycle pulse: a result register was just updated
- busy  out  1  high from the cycle after `nxt` until return to IDLE
- err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset values (one clock with rst=1):
  - all result registers 12'h000; wrt, vld, busy, err all 0; cmd 16'h0000
  - round-robin pointer rr = 0 (left load cell); state IDLE; timeout counter 0
- Channel command format: cmd = {2'b00, chnl[2:0], 11'h000}, where chnl is selected by rr (0→CH_LFT, 1→CH_RGHT, 2→CH_STEER, 3→CH_BATT).
- `cmd` is registered and held constant from the first `wrt` until IDLE.
- IDLE:
  - on `nxt`=1: load cmd, pulse wrt next cycle, set busy, go to XFER1.
- XFER1:
  - wait for `done`, then go to GAP; rd_data is ignored.
- GAP:
  - exactly one idle cycle, so the ADC sees SS_n high between frames.
  - then pulse wrt with the same cmd and go to XFER2.
- XFER2:
  - on `done`: capture rd_data[11:0] into the register selected by rr on that same edge.
  - pulse vld the following cycle; rr wraps 3→0; clear busy; go to IDLE.
- Latency: nxt-to-first-wrt is 1 clock. done(XFER1)-to-second-wrt is 2 clocks (GAP, then wrt). done(XFER2)-to-vld is 1 clock.
- Timeout:
  - the counter clears on every wrt and increments each cycle in XFER1/XFER2.
  - on reaching TMO_CYC-1 without `done`: pulse err, go to IDLE, clear busy.
  - rr does not advance and no result register changes, so the same channel is retried on the next nxt.
- Simultaneous events:
  - nxt while busy is ignored; it is not queued.
  - done in IDLE or GAP is ignored.
  - done on the same cycle as the timeout terminal count: done wins, no err.
- Reset mid-transaction returns every state above to its reset value on that edge. No partial results are written.
- Result registers hold their value between updates. Only one register changes per conversion.

Decomposition:
- Shared package segway_pkg holds:
  - typedef enum a2d_state_t {IDLE, XFER1, GAP, XFER2}
  - the localparam channel defaults
  - the helper function a2d_cmd(chnl) that builds the 16-bit command word
- No sub-module is required. The timeout counter and rr pointer are inline.
- The SPI monarch is a peer instance wired at the Segway top level; it is not instantiated inside this block.

Test Plan:
- After reset, pulse nxt with a stub monarch returning rd_data=16'h0356 → cmd=16'h0000 on two wrt pulses separated by one GAP cycle; lft_ld=12'h356 and one vld pulse 1 clk after the second done.
- Four consecutive nxt with ADC model values ld_cell_rght=12'h356, steerPot=12'h100, batt=12'h900 → cmd sequence 0x0000, 0x2000, 0x2800, 0x3000; the fifth nxt wraps to 0x0000; all four registers correct.
- Pulse nxt during XFER1 and again during XFER2 → no extra wrt, rr advances by exactly 1, busy stays contiguous.
- Stub never asserts done → err pulses exactly TMO_CYC cycles after wrt, busy drops, lft_ld unchanged; the next nxt reissues cmd=16'h0000.
- Assert rst during XFER2 with done on the same cycle → registers stay 12'h000, no vld, rr=0, busy=0 next cycle.
- done coincident with timeout terminal count in XFER2 → vld=1, err=0, result captured.
